// File: rtl/sonic_scheduler.sv
// Round-robin ultrasonic ranging controller: one measurement engine is time-shared
// across N_SENSORS sensors, firing one trigger at a time and timing its echo in microseconds.
module sonic_scheduler #(
  parameter int N_SENSORS  = 3,
  parameter int CLK_PER_US = 100,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 10000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_SENSORS-1:0]      echo,
  output logic [N_SENSORS-1:0]      trig,
  output logic [20*N_SENSORS-1:0]   distance,
  output logic [N_SENSORS-1:0]      timeout,
  output logic                      done,
  output logic [2:0]                done_id,
  output logic                      busy,
  output logic [2:0]                sel,
  output logic [2:0]                state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_CONVERT   = 3'd4,
    S_TIMEOUT   = 3'd5,
    S_GAP       = 3'd6
  } state_t;

  localparam int            PW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(CLK_PER_US - 1);
  localparam logic [19:0]   TRIG_LAST = 20'(TRIG_US - 1);
  localparam logic [19:0]   GAP_LAST  = 20'(GAP_US - 1);
  localparam logic [19:0]   TO_LAST   = 20'(TIMEOUT_US - 1);
  localparam logic [19:0]   WIDTH_MAX = 20'hFFFFF;

  state_t               state, state_nx;
  logic [PW-1:0]        presc;
  logic                 tick;
  logic [19:0]          us_cnt;
  logic [19:0]          to_cnt;
  logic [19:0]          width;
  logic [N_SENSORS-1:0] sync1, sync2, sync3;
  logic [7:0]           sync2_pad, sync3_pad;
  logic                 echo_rise, echo_fall, to_hit;
  logic [2:0]           sel_nx;
  logic [24:0]          product;
  logic [19:0]          dist_cm;

  // Two flops for metastability, a third purely to detect edges on the settled value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_comb begin
    sync2_pad = '0;
    sync3_pad = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      sync2_pad[i] = sync2[i];
      sync3_pad[i] = sync3[i];
    end
  end

  assign echo_rise = sync2_pad[sel] & ~sync3_pad[sel];
  assign echo_fall = ~sync2_pad[sel] & sync3_pad[sel];
  assign tick      = (presc == PS_LAST);
  assign to_hit    = tick && (to_cnt == TO_LAST);
  assign sel_nx    = (sel == 3'(N_SENSORS - 1)) ? 3'd0 : sel + 3'd1;
  assign product   = 25'(width) * 25'd17;
  assign dist_cm   = 20'(product / 25'd1000);

  // Timeout is checked before echo edges so a fall on the deadline cycle still times out.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:      if (enable) state_nx = S_TRIG;
      S_TRIG:      if (tick && us_cnt == TRIG_LAST) state_nx = S_WAIT_RISE;
      S_WAIT_RISE: begin
        if (to_hit)         state_nx = S_TIMEOUT;
        else if (echo_rise) state_nx = S_MEASURE;
      end
      S_MEASURE: begin
        if (to_hit)         state_nx = S_TIMEOUT;
        else if (echo_fall) state_nx = S_CONVERT;
      end
      S_CONVERT:   state_nx = S_GAP;
      S_TIMEOUT:   state_nx = S_GAP;
      S_GAP:       if (tick && us_cnt == GAP_LAST) state_nx = enable ? S_TRIG : S_IDLE;
      default:     state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Prescaler and us counter restart on every transition so each state begins on a tick boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc  <= '0;
      us_cnt <= '0;
      to_cnt <= '0;
      width  <= '0;
    end else begin
      if (state_nx != state) begin
        presc  <= '0;
        us_cnt <= '0;
      end else begin
        presc <= tick ? '0 : presc + 1'b1;
        if (tick) us_cnt <= us_cnt + 20'd1;
      end
      if (state == S_WAIT_RISE || state == S_MEASURE) begin
        if (tick) to_cnt <= to_cnt + 20'd1;
      end else begin
        to_cnt <= '0;
      end
      if (state == S_MEASURE) begin
        if (tick && width != WIDTH_MAX) width <= width + 20'd1;
      end else begin
        width <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      distance <= '0;
      timeout  <= '0;
    end else begin
      if (state == S_GAP && state_nx != S_GAP) sel <= sel_nx;
      for (int i = 0; i < N_SENSORS; i++) begin
        if (sel == 3'(i)) begin
          if (state == S_CONVERT) begin
            distance[20*i +: 20] <= dist_cm;
            timeout[i]           <= 1'b0;
          end else if (state == S_TIMEOUT) begin
            timeout[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Outputs decode straight from the state register; done is a one-cycle strobe with no back-pressure.
  always_comb begin
    trig = '0;
    for (int i = 0; i < N_SENSORS; i++) begin
      if (state == S_TRIG && sel == 3'(i)) trig[i] = 1'b1;
    end
  end

  assign done      = (state == S_CONVERT) || (state == S_TIMEOUT);
  assign done_id   = done ? sel : 3'd0;
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule
